// File: rtl/mpt_plb.sv
// Protection lookaside buffer: caches per-page {X,W,R} permissions in front of
// the MPT walker, answers hits locally and refills from the walker on a miss.
module mpt_plb #(
    parameter int unsigned NUM_ENTRIES = 4,
    parameter int unsigned SPA_WIDTH   = 34,
    parameter int unsigned PG_OFFSET   = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 enable_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [SPA_WIDTH-1:0] req_spa_i,
    input  logic [1:0]           req_access_i,
    output logic                 resp_valid_o,
    output logic                 resp_allow_o,
    output logic                 resp_fault_o,
    output logic                 ptw_req_o,
    output logic [SPA_WIDTH-1:0] ptw_spa_o,
    output logic [1:0]           ptw_access_o,
    input  logic                 ptw_valid_i,
    input  logic                 ptw_fault_i,
    input  logic [2:0]           ptw_perm_i
);

    localparam int unsigned TAG_W = SPA_WIDTH - PG_OFFSET;
    localparam int unsigned IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    // One-hot so every control output is a flop bit.
    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        LOOKUP = 4'b0010,
        WALK   = 4'b0100,
        RESP   = 4'b1000
    } state_e;

    state_e state_q, state_d;

    logic [SPA_WIDTH-1:0]   spa_q, spa_d;
    logic [1:0]             acc_q, acc_d;
    logic                   allow_q, allow_d;
    logic                   fault_q, fault_d;
    logic [NUM_ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]       tag_q  [NUM_ENTRIES];
    logic [2:0]             perm_q [NUM_ENTRIES];
    logic [IDX_W-1:0]       rr_q, rr_d;

    logic [TAG_W-1:0] req_tag;
    logic             hit;
    logic [2:0]       hit_perm;
    logic [IDX_W-1:0] victim;
    logic             refill;

    function automatic logic perm_bit(input logic [2:0] perm, input logic [1:0] acc);
        logic b;
        case (acc)
            2'd0:    b = perm[0];
            2'd1:    b = perm[1];
            2'd2:    b = perm[2];
            default: b = 1'b0;
        endcase
        return b;
    endfunction

    assign req_tag = spa_q[SPA_WIDTH-1:PG_OFFSET];

    // Fully-associative tag match; at most one entry can hit.
    always_comb begin
        hit      = 1'b0;
        hit_perm = 3'b000;
        for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
            if (valid_q[i] && (tag_q[i] == req_tag)) begin
                hit      = 1'b1;
                hit_perm = hit_perm | perm_q[i];
            end
        end
    end

    // Lowest-index free entry, otherwise the round-robin pointer.
    always_comb begin
        victim = rr_q;
        for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
            if (!valid_q[i]) victim = IDX_W'(i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid_i) state_d = LOOKUP;
            LOOKUP:  if (!enable_i || (acc_q == 2'd3) || hit) state_d = RESP;
                     else                                     state_d = WALK;
            WALK:    if (ptw_valid_i || ptw_fault_i) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    always_comb begin
        req_ready_o  = state_q[0];
        ptw_req_o    = state_q[2];
        resp_valid_o = state_q[3];
        resp_allow_o = allow_q;
        resp_fault_o = fault_q;
        ptw_spa_o    = spa_q;
        ptw_access_o = acc_q;
    end

    // Request latch, verdict and refill control.
    always_comb begin
        spa_d   = spa_q;
        acc_d   = acc_q;
        allow_d = allow_q;
        fault_d = fault_q;
        valid_d = valid_q;
        rr_d    = rr_q;
        refill  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    spa_d = req_spa_i;
                    acc_d = req_access_i;
                end
            end
            LOOKUP: begin
                allow_d = 1'b0;
                fault_d = 1'b0;
                if (!enable_i)            allow_d = 1'b1;
                else if (acc_q == 2'd3)   fault_d = 1'b1;
                else if (hit)             allow_d = perm_bit(hit_perm, acc_q);
            end
            WALK: begin
                if (ptw_fault_i) begin
                    allow_d = 1'b0;
                    fault_d = 1'b1;
                end else if (ptw_valid_i) begin
                    allow_d         = perm_bit(ptw_perm_i, acc_q);
                    fault_d         = 1'b0;
                    refill          = 1'b1;
                    valid_d[victim] = 1'b1;
                    if (&valid_q) rr_d = rr_q + IDX_W'(1);
                end
            end
            default: ;
        endcase
        // Flush discards everything, including a refill landing this cycle.
        if (flush_i) begin
            valid_d = '0;
            refill  = 1'b0;
            rr_d    = rr_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            spa_q   <= '0;
            acc_q   <= '0;
            allow_q <= 1'b0;
            fault_q <= 1'b0;
            valid_q <= '0;
            rr_q    <= '0;
            for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
                tag_q[i]  <= '0;
                perm_q[i] <= '0;
            end
        end else begin
            spa_q   <= spa_d;
            acc_q   <= acc_d;
            allow_q <= allow_d;
            fault_q <= fault_d;
            valid_q <= valid_d;
            rr_q    <= rr_d;
            if (refill) begin
                tag_q[victim]  <= req_tag;
                perm_q[victim] <= ptw_perm_i;
            end
        end
    end

endmodule

// File: tb/tb_mpt_plb.sv
// Self-checking bench for mpt_plb: directed vector table, flush corner cases,
// and randomized traffic against a page-permission cache reference model.
`timescale 1ns/1ps
module tb_mpt_plb;

    localparam int unsigned N  = 4;
    localparam int unsigned SW = 34;
    localparam int unsigned PO = 12;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          flush_i;
    logic          enable_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [SW-1:0] req_spa_i;
    logic [1:0]    req_access_i;
    logic          resp_valid_o;
    logic          resp_allow_o;
    logic          resp_fault_o;
    logic          ptw_req_o;
    logic [SW-1:0] ptw_spa_o;
    logic [1:0]    ptw_access_o;
    logic          ptw_valid_i;
    logic          ptw_fault_i;
    logic [2:0]    ptw_perm_i;

    always #5 clk_i = ~clk_i;

    mpt_plb #(.NUM_ENTRIES(N), .SPA_WIDTH(SW), .PG_OFFSET(PO)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .enable_i     (enable_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_spa_i    (req_spa_i),
        .req_access_i (req_access_i),
        .resp_valid_o (resp_valid_o),
        .resp_allow_o (resp_allow_o),
        .resp_fault_o (resp_fault_o),
        .ptw_req_o    (ptw_req_o),
        .ptw_spa_o    (ptw_spa_o),
        .ptw_access_o (ptw_access_o),
        .ptw_valid_i  (ptw_valid_i),
        .ptw_fault_i  (ptw_fault_i),
        .ptw_perm_i   (ptw_perm_i)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0b expected %0b", name, act, exp);
    endtask

    task automatic check_val(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference model: a list of cached pages with permissions and a replacement pointer.
    logic          m_valid [N];
    logic [SW-PO-1:0] m_tag [N];
    logic [2:0]    m_perm  [N];
    int            m_rr;

    function automatic logic rule_bit(input logic [2:0] p, input logic [1:0] a);
        return ((p >> a) & 3'b001) != 3'b000;
    endfunction

    function automatic void model_flush();
        for (int i = 0; i < int'(N); i++) m_valid[i] = 1'b0;
    endfunction

    // kind: 0 walker returns valid, 1 walker faults, 2 both pulses together.
    function automatic void model_req(input logic [SW-1:0] spa, input logic [1:0] acc,
                                      input logic en, input int kind, input logic [2:0] perm,
                                      output logic w, output logic a, output logic f);
        int hit_idx;
        int vic;
        logic [SW-PO-1:0] tag;
        hit_idx = -1;
        vic     = -1;
        tag     = spa[SW-1:PO];
        w = 1'b0; a = 1'b0; f = 1'b0;
        if (!en) begin a = 1'b1; return; end
        if (acc == 2'd3) begin f = 1'b1; return; end
        for (int i = 0; i < int'(N); i++) if (m_valid[i] && m_tag[i] == tag) hit_idx = i;
        if (hit_idx >= 0) begin a = rule_bit(m_perm[hit_idx], acc); return; end
        w = 1'b1;
        if (kind != 0) begin f = 1'b1; return; end
        a = rule_bit(perm, acc);
        for (int i = int'(N) - 1; i >= 0; i--) if (!m_valid[i]) vic = i;
        if (vic < 0) begin
            vic  = m_rr;
            m_rr = (m_rr + 1) % int'(N);
        end
        m_valid[vic] = 1'b1;
        m_tag[vic]   = tag;
        m_perm[vic]  = perm;
    endfunction

    task automatic do_flush();
        @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
    endtask

    // Issue one request, play the walker if asked, collect the response.
    task automatic run_req(input logic [SW-1:0] spa, input logic [1:0] acc, input int kind,
                           input logic [2:0] perm, input int delay,
                           output logic walked, output logic allow, output logic fault,
                           output int lat, output int pulse_cyc);
        int   cyc;
        int   waited;
        logic got;
        walked = 1'b0; allow = 1'b0; fault = 1'b0;
        lat = -1; pulse_cyc = -1; waited = 0; got = 1'b0;
        @(negedge clk_i);
        check_bit("ready_idle", req_ready_o, 1'b1);
        req_valid_i  = 1'b1;
        req_spa_i    = spa;
        req_access_i = acc;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        check_bit("ready_busy", req_ready_o, 1'b0);
        cyc = 1;
        while (!got && cyc < 64) begin
            ptw_valid_i = 1'b0;
            ptw_fault_i = 1'b0;
            if (resp_valid_o) begin
                got   = 1'b1;
                allow = resp_allow_o;
                fault = resp_fault_o;
                lat   = cyc;
            end else begin
                if (ptw_req_o && pulse_cyc < 0) begin
                    if (!walked) begin
                        walked = 1'b1;
                        check_val("ptw_spa", longint'(ptw_spa_o), longint'(spa));
                        check_val("ptw_access", longint'(ptw_access_o), longint'(acc));
                    end
                    if (waited == delay) begin
                        pulse_cyc   = cyc;
                        ptw_perm_i  = perm;
                        ptw_valid_i = (kind != 1);
                        ptw_fault_i = (kind != 0);
                    end else begin
                        waited++;
                    end
                end
                @(negedge clk_i);
                cyc++;
            end
        end
        ptw_valid_i = 1'b0;
        ptw_fault_i = 1'b0;
        check_bit("resp_seen", got, 1'b1);
        if (got) begin
            @(negedge clk_i);
            check_bit("resp_one_cycle", resp_valid_o, 1'b0);
        end
    endtask

    typedef struct {
        logic          flush_before;
        logic          en;
        logic [SW-1:0] spa;
        logic [1:0]    acc;
        int            kind;
        logic [2:0]    perm;
        logic          exp_walk;
        logic          exp_allow;
        logic          exp_fault;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    // Checks one response against expected walk/allow/fault plus latency rules.
    task automatic judge(input string tag, input logic walked, input logic allow, input logic fault,
                         input int lat, input int pulse_cyc,
                         input logic ew, input logic ea, input logic ef);
        check_bit({tag, "_walk"},  walked, ew);
        check_bit({tag, "_allow"}, allow,  ea);
        check_bit({tag, "_fault"}, fault,  ef);
        if (walked) check_val({tag, "_lat_walk"}, longint'(lat), longint'(pulse_cyc + 1));
        else        check_val({tag, "_lat_hit"},  longint'(lat), 64'sd2);
    endtask

    logic w, a, f, mw, ma, mf, seen, any;
    int   lat, pc;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0; enable_i = 1'b1; req_valid_i = 1'b0;
        req_spa_i = '0; req_access_i = 2'd0;
        ptw_valid_i = 1'b0; ptw_fault_i = 1'b0; ptw_perm_i = 3'b000;
        m_rr = 0;
        model_flush();

        vecs[0]  = '{1'b0, 1'b1, 34'h080001234, 2'd0, 0, 3'b001, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 34'h080001FFC, 2'd0, 0, 3'b111, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 34'h080001FFC, 2'd1, 0, 3'b111, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 34'h000001000, 2'd2, 1, 3'b111, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 34'h000001000, 2'd2, 0, 3'b100, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 34'h000001000, 2'd0, 0, 3'b001, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 34'h000002000, 2'd0, 0, 3'b011, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 34'h000003000, 2'd1, 0, 3'b010, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 34'h000004000, 2'd2, 0, 3'b100, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 34'h000005000, 2'd0, 0, 3'b001, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 34'h000002000, 2'd1, 0, 3'b000, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 34'h000001000, 2'd0, 0, 3'b001, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 34'h000007777, 2'd1, 0, 3'b000, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 34'h3FFFFF000, 2'd3, 0, 3'b000, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 34'h000005000, 2'd3, 0, 3'b111, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 34'h000005000, 2'd0, 0, 3'b000, 1'b0, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 34'h000009000, 2'd0, 2, 3'b111, 1'b1, 1'b0, 1'b1};
        vecs[17] = '{1'b0, 1'b1, 34'h000009000, 2'd0, 0, 3'b111, 1'b1, 1'b1, 1'b0};

        repeat (3) @(negedge clk_i);
        check_bit("rst_ready", req_ready_o, 1'b1);
        check_bit("rst_resp_valid", resp_valid_o, 1'b0);
        check_bit("rst_allow", resp_allow_o, 1'b0);
        check_bit("rst_fault", resp_fault_o, 1'b0);
        check_bit("rst_ptw_req", ptw_req_o, 1'b0);
        check_val("rst_ptw_spa", longint'(ptw_spa_o), 64'sd0);
        check_val("rst_ptw_access", longint'(ptw_access_o), 64'sd0);
        rst_ni = 1'b1;

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].flush_before) begin
                do_flush();
                model_flush();
            end
            enable_i = vecs[i].en;
            model_req(vecs[i].spa, vecs[i].acc, vecs[i].en, vecs[i].kind, vecs[i].perm, mw, ma, mf);
            run_req(vecs[i].spa, vecs[i].acc, vecs[i].kind, vecs[i].perm, i % 3, w, a, f, lat, pc);
            judge($sformatf("vec%0d", i), w, a, f, lat, pc,
                  vecs[i].exp_walk, vecs[i].exp_allow, vecs[i].exp_fault);
        end
        enable_i = 1'b1;

        // Flush while walking: request vanishes, late walker pulse is ignored.
        @(negedge clk_i);
        req_valid_i = 1'b1; req_spa_i = 34'h00000A000; req_access_i = 2'd0;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            if (ptw_req_o) seen = 1'b1;
            else @(negedge clk_i);
        end
        check_bit("flush_walk_started", seen, 1'b1);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        check_bit("flush_ptw_drop", ptw_req_o, 1'b0);
        check_bit("flush_ready", req_ready_o, 1'b1);
        ptw_valid_i = 1'b1; ptw_perm_i = 3'b111;
        any = resp_valid_o;
        @(negedge clk_i);
        ptw_valid_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            any = any | resp_valid_o;
            @(negedge clk_i);
        end
        check_bit("flush_no_resp", any, 1'b0);
        model_flush();
        model_req(34'h000005000, 2'd0, 1'b1, 0, 3'b001, mw, ma, mf);
        run_req(34'h000005000, 2'd0, 0, 3'b001, 1, w, a, f, lat, pc);
        judge("post_flush", w, a, f, lat, pc, 1'b1, 1'b1, 1'b0);

        // Flush and walker-valid in the same cycle: no refill, no response.
        @(negedge clk_i);
        req_valid_i = 1'b1; req_spa_i = 34'h00000B000; req_access_i = 2'd0;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            if (ptw_req_o) seen = 1'b1;
            else @(negedge clk_i);
        end
        check_bit("flushvalid_walk_started", seen, 1'b1);
        flush_i = 1'b1; ptw_valid_i = 1'b1; ptw_perm_i = 3'b111;
        @(negedge clk_i);
        flush_i = 1'b0; ptw_valid_i = 1'b0;
        any = 1'b0;
        for (int c = 0; c < 4; c++) begin
            any = any | resp_valid_o;
            @(negedge clk_i);
        end
        check_bit("flushvalid_no_resp", any, 1'b0);
        model_flush();
        model_req(34'h00000B000, 2'd0, 1'b1, 0, 3'b101, mw, ma, mf);
        run_req(34'h00000B000, 2'd0, 0, 3'b101, 0, w, a, f, lat, pc);
        judge("flushvalid_rewalk", w, a, f, lat, pc, 1'b1, 1'b1, 1'b0);

        // Randomized traffic over a small page pool so hits and evictions both occur.
        for (int it = 0; it < 300; it++) begin
            logic [SW-1:0] spa;
            logic [21:0]   pg;
            logic [1:0]    acc;
            logic [2:0]    perm;
            logic          en;
            int            kind;
            int            r;
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                do_flush();
                model_flush();
            end else if (r == 1) begin
                @(negedge clk_i);
                ptw_valid_i = 1'b1; ptw_perm_i = 3'($urandom);
                @(negedge clk_i);
                ptw_valid_i = 1'b0;
            end
            en   = ($urandom_range(0, 9) != 0);
            pg   = 22'($urandom_range(0, 7)) * 22'h040001;
            spa  = {pg, 12'($urandom)};
            acc  = 2'($urandom_range(0, 3));
            perm = 3'($urandom);
            r    = int'($urandom_range(0, 5));
            kind = (r < 4) ? 0 : ((r == 4) ? 1 : 2);
            enable_i = en;
            model_req(spa, acc, en, kind, perm, mw, ma, mf);
            run_req(spa, acc, kind, perm, int'($urandom_range(0, 3)), w, a, f, lat, pc);
            judge($sformatf("rnd%0d", it), w, a, f, lat, pc, mw, ma, mf);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
